// File: rtl/clksrc_pkg.sv
// Shared types and helpers for the clksrc PLL control blocks.
//   clksrc_state_t      : lock controller state encoding
//   clksrc_timer_width  : width of a timer that must hold the largest of three cycle counts
package clksrc_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    READY     = 3'd3,
    FAIL      = 3'd4
  } clksrc_state_t;

  // Bits needed to count up to the largest of the three cycle parameters.
  function automatic int unsigned clksrc_timer_width(input int unsigned rst_cycles,
                                                     input int unsigned lock_timeout,
                                                     input int unsigned stable_cycles);
    int unsigned m;
    m = rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clksrc_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk edges of latency)
module clksrc_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clksrc_lock_ctrl.sv
// PLL reset / lock qualification controller running on the free-running refclk.
// Holds the PLL in reset, waits for a synchronized lock, requires the lock to stay
// up for STABLE_CYCLES before raising pll_ready, and retries on lock timeout until
// MAX_RETRIES timeouts have occurred, after which fail latches.
// Ports:
//   refclk     : reference clock (only clock)
//   rst_n      : asynchronous active-low reset
//   pll_locked : PLL lock indicator, asynchronous to refclk
//   soft_rst   : synchronous single-cycle restart request
//   pll_rst    : PLL reset, active-high
//   pll_ready  : lock qualified stable
//   fail       : sticky retry exhaustion
//   retry_cnt  : timeouts since last ready or restart
//   loss_cnt   : (only with CLKSRC_LOSS_CNT_EN) saturating count of lock losses from READY
// Build option: define CLKSRC_LOSS_CNT_EN to add the loss_cnt output and counter.
module clksrc_lock_ctrl
  import clksrc_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 5000,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                               refclk,
  input  logic                               rst_n,
  input  logic                               pll_locked,
  input  logic                               soft_rst,
  output logic                               pll_rst,
  output logic                               pll_ready,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
`ifdef CLKSRC_LOSS_CNT_EN
  ,
  output logic [7:0]                         loss_cnt
`endif
);

  localparam int unsigned TIMER_W = clksrc_timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
  // The WAIT_LOCK cycle that first sees the lock counts as the first stable cycle,
  // so STABLE itself only needs STABLE_CYCLES-1 more locked cycles.
  localparam int unsigned STABLE_LAST = (STABLE_CYCLES >= 2) ? (STABLE_CYCLES - 2) : 0;

  clksrc_state_t        state;
  clksrc_state_t        next_state;
  logic [TIMER_W-1:0]   timer;
  logic [RETRY_W-1:0]   retry_nxt;
  logic                 locked_s;

  // Bring the PLL lock into the refclk domain.
  clksrc_sync2 #(
    .RST_VAL(1'b0)
  ) u_lock_sync (
    .clk  (refclk),
    .rst_n(rst_n),
    .d    (pll_locked),
    .q    (locked_s)
  );

  // Next-state and next retry count.
  always_comb begin
    next_state = state;
    retry_nxt  = retry_cnt;
    if (soft_rst) begin
      next_state = RESET_PLL;
      retry_nxt  = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (timer == TIMER_W'(RST_CYCLES - 1)) next_state = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            next_state = (STABLE_CYCLES == 1) ? READY : STABLE;
          end else if (timer == TIMER_W'(LOCK_TIMEOUT - 1)) begin
            retry_nxt  = retry_cnt + RETRY_W'(1);
            next_state = (retry_nxt == RETRY_W'(MAX_RETRIES)) ? FAIL : RESET_PLL;
          end
        end
        STABLE: begin
          if (!locked_s) next_state = WAIT_LOCK;
          else if (timer == TIMER_W'(STABLE_LAST)) next_state = READY;
        end
        READY: begin
          if (!locked_s) next_state = RESET_PLL;
        end
        FAIL:    next_state = FAIL;
        default: next_state = RESET_PLL;
      endcase
    end
    if (next_state == READY) retry_nxt = '0;
  end

  // State, timer and outputs; outputs are decoded from next_state so they move with the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      timer     <= '0;
      pll_rst   <= 1'b1;
      pll_ready <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state     <= next_state;
      retry_cnt <= retry_nxt;
      pll_rst   <= (next_state == RESET_PLL) || (next_state == FAIL);
      pll_ready <= (next_state == READY);
      fail      <= (next_state == FAIL);
      if (soft_rst || (next_state != state)) begin
        timer <= '0;
      end else if ((state == RESET_PLL) || (state == WAIT_LOCK) || (state == STABLE)) begin
        timer <= timer + TIMER_W'(1);
      end
    end
  end

`ifdef CLKSRC_LOSS_CNT_EN
  // Lock losses out of READY; a restart request is not a loss.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= 8'd0;
    end else if (!soft_rst && (state == READY) && !locked_s && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clksrc_lock_ctrl.sv
// Bench for clksrc_lock_ctrl: directed scenarios plus randomized lock activity
// compared against a cycle-level behavioural model of the controller.
module tb_clksrc_lock_ctrl;

  localparam int unsigned RST_C = 4;
  localparam int unsigned TMO   = 20;
  localparam int unsigned STB   = 8;
  localparam int unsigned MAXR  = 3;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_rst;
  logic       pll_rst;
  logic       pll_ready;
  logic       fail;
  logic [1:0] retry_cnt;
`ifdef CLKSRC_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  clksrc_lock_ctrl #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (TMO),
    .STABLE_CYCLES(STB),
    .MAX_RETRIES  (MAXR)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .soft_rst  (soft_rst),
    .pll_rst   (pll_rst),
    .pll_ready (pll_ready),
    .fail      (fail),
    .retry_cnt (retry_cnt)
`ifdef CLKSRC_LOSS_CNT_EN
    ,
    .loss_cnt  (loss_cnt)
`endif
  );

  always #5 refclk = ~refclk;

  // Behavioural model: which phase the controller is in, how long it has been there,
  // how many consecutive locked samples have been seen, and the retry/loss tallies.
  localparam int M_RST = 0, M_WAIT = 1, M_STB = 2, M_RDY = 3, M_FAIL = 4;
  int   m_mode, m_n, m_run, m_retries, m_loss;
  logic m_s1, m_s2;

  function automatic logic e_rst();
    return (m_mode == M_RST) || (m_mode == M_FAIL);
  endfunction
  function automatic logic e_rdy();
    return m_mode == M_RDY;
  endfunction
  function automatic logic e_fail();
    return m_mode == M_FAIL;
  endfunction

  task automatic model_reset();
    m_mode = M_RST; m_n = 0; m_run = 0; m_retries = 0; m_loss = 0;
    m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  task automatic model_step();
    logic ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_locked;
    if (soft_rst) begin
      m_mode = M_RST; m_n = 0; m_retries = 0;
    end else begin
      case (m_mode)
        M_RST: begin
          m_n++;
          if (m_n == int'(RST_C)) begin m_mode = M_WAIT; m_n = 0; end
        end
        M_WAIT: begin
          if (ls) begin
            m_run = 1;
            if (m_run == int'(STB)) begin m_mode = M_RDY; m_retries = 0; end
            else m_mode = M_STB;
          end else begin
            m_n++;
            if (m_n == int'(TMO)) begin
              m_retries++;
              m_mode = (m_retries == int'(MAXR)) ? M_FAIL : M_RST;
              m_n = 0;
            end
          end
        end
        M_STB: begin
          if (!ls) begin m_mode = M_WAIT; m_n = 0; end
          else begin
            m_run++;
            if (m_run == int'(STB)) begin m_mode = M_RDY; m_retries = 0; end
          end
        end
        M_RDY: begin
          if (!ls) begin
            m_mode = M_RST; m_n = 0;
            if (m_loss < 255) m_loss++;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One refclk edge; outputs are settled 1 ns later.
  task automatic cycle();
    @(posedge refclk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0; soft_rst = 1'b0;
    model_reset();
    #12;
    checks++; if (pll_rst !== 1'b1) begin errs++; $display("FAIL reset_pll_rst got=%b want=1", pll_rst); end
    checks++; if (pll_ready !== 1'b0) begin errs++; $display("FAIL reset_pll_ready got=%b want=0", pll_ready); end
    checks++; if (fail !== 1'b0) begin errs++; $display("FAIL reset_fail got=%b want=0", fail); end
    checks++; if (retry_cnt !== 2'd0) begin errs++; $display("FAIL reset_retry got=%0d want=0", retry_cnt); end
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock_basic();
    int n;
    pll_locked = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin cycle(); n++; end
    checks++; if (n != 4) begin errs++; $display("FAIL basic_rst_len got=%0d want=4", n); end
    repeat (5) cycle();
    checks++; if (pll_rst !== 1'b0) begin errs++; $display("FAIL basic_wait_rst got=%b want=0", pll_rst); end
    pll_locked = 1'b1;
    n = 0;
    while (pll_ready !== 1'b1 && n < 50) begin cycle(); n++; end
    checks++; if (n != 10) begin errs++; $display("FAIL basic_ready_lat got=%0d want=10", n); end
    checks++; if (retry_cnt !== 2'd0) begin errs++; $display("FAIL basic_retry got=%0d want=0", retry_cnt); end
    checks++; if (pll_rst !== e_rst()) begin errs++; $display("FAIL basic_model_rst got=%b want=%b", pll_rst, e_rst()); end
  endtask

  task automatic test_lock_loss();
    int n;
    pll_locked = 1'b0;
    n = 0;
    while (pll_ready === 1'b1 && n < 20) begin cycle(); n++; end
    checks++; if (n != 3) begin errs++; $display("FAIL loss_edges got=%0d want=3", n); end
    checks++; if (pll_rst !== 1'b1) begin errs++; $display("FAIL loss_pll_rst got=%b want=1", pll_rst); end
`ifdef CLKSRC_LOSS_CNT_EN
    checks++; if (loss_cnt !== 8'd1) begin errs++; $display("FAIL loss_cnt got=%0d want=1", loss_cnt); end
`endif
  endtask

  task automatic test_timeout_fail();
    int n;
    do_reset();
    pll_locked = 1'b0;
    n = 0;
    while (fail !== 1'b1 && n < 200) begin
      cycle(); n++;
      checks++; if (pll_rst !== e_rst()) begin errs++; $display("FAIL tmo_pll_rst cyc=%0d got=%b want=%b", cyc, pll_rst, e_rst()); end
      checks++; if (retry_cnt !== 2'(m_retries)) begin errs++; $display("FAIL tmo_retry cyc=%0d got=%0d want=%0d", cyc, retry_cnt, m_retries); end
    end
    checks++; if (n != 72) begin errs++; $display("FAIL tmo_fail_edge got=%0d want=72", n); end
    checks++; if (retry_cnt !== 2'd3) begin errs++; $display("FAIL tmo_retry_final got=%0d want=3", retry_cnt); end
    repeat (30) begin
      cycle();
      checks++;
      if ({pll_rst, fail, pll_ready} !== 3'b110) begin
        errs++; $display("FAIL fail_hold cyc=%0d got rst/fail/rdy=%b want=110", cyc, {pll_rst, fail, pll_ready});
      end
    end
  endtask

  task automatic test_soft_from_fail();
    int n;
    soft_rst = 1'b1;
    cycle();
    soft_rst = 1'b0;
    checks++; if (fail !== 1'b0) begin errs++; $display("FAIL soft_fail got=%b want=0", fail); end
    checks++; if (retry_cnt !== 2'd0) begin errs++; $display("FAIL soft_retry got=%0d want=0", retry_cnt); end
    checks++; if (pll_rst !== 1'b1) begin errs++; $display("FAIL soft_pll_rst got=%b want=1", pll_rst); end
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin cycle(); n++; end
    checks++; if (n != 4) begin errs++; $display("FAIL soft_rst_len got=%0d want=4", n); end
  endtask

  task automatic test_glitch();
    int n;
    pll_locked = 1'b1;
    repeat (5) begin
      cycle();
      checks++; if (pll_ready !== 1'b0) begin errs++; $display("FAIL glitch_hi_ready cyc=%0d got=%b want=0", cyc, pll_ready); end
    end
    pll_locked = 1'b0;
    repeat (3) begin
      cycle();
      checks++; if (pll_ready !== 1'b0) begin errs++; $display("FAIL glitch_lo_ready cyc=%0d got=%b want=0", cyc, pll_ready); end
    end
    pll_locked = 1'b1;
    n = 0;
    while (pll_ready !== 1'b1 && n < 50) begin
      cycle(); n++;
      checks++; if (pll_ready !== e_rdy()) begin errs++; $display("FAIL glitch_model_ready cyc=%0d got=%b want=%b", cyc, pll_ready, e_rdy()); end
    end
    checks++; if (n != 10) begin errs++; $display("FAIL glitch_ready_lat got=%0d want=10", n); end
    checks++; if (retry_cnt !== 2'd0) begin errs++; $display("FAIL glitch_retry got=%0d want=0", retry_cnt); end
  endtask

  task automatic test_soft_at_timeout();
    do_reset();
    pll_locked = 1'b0;
    repeat (47) cycle();
    checks++; if (retry_cnt !== 2'd1) begin errs++; $display("FAIL softtmo_pre_retry got=%0d want=1", retry_cnt); end
    soft_rst = 1'b1;
    cycle();
    soft_rst = 1'b0;
    checks++; if (retry_cnt !== 2'd0) begin errs++; $display("FAIL softtmo_retry got=%0d want=0", retry_cnt); end
    checks++; if (pll_rst !== 1'b1) begin errs++; $display("FAIL softtmo_pll_rst got=%b want=1", pll_rst); end
    checks++; if (fail !== 1'b0) begin errs++; $display("FAIL softtmo_fail got=%b want=0", fail); end
    checks++; if (m_mode != M_RST) begin errs++; $display("FAIL softtmo_model_mode got=%0d want=%0d", m_mode, M_RST); end
  endtask

  task automatic test_async_reset();
    do_reset();
    pll_locked = 1'b0;
    repeat (28) cycle();
    pll_locked = 1'b1;
    repeat (4) cycle();
    checks++; if ({pll_rst, pll_ready, retry_cnt} !== {e_rst(), e_rdy(), 2'(m_retries)}) begin
      errs++; $display("FAIL async_pre got=%b%b%0d want=%b%b%0d", pll_rst, pll_ready, retry_cnt, e_rst(), e_rdy(), m_retries);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (pll_rst !== 1'b1) begin errs++; $display("FAIL async_pll_rst got=%b want=1", pll_rst); end
    checks++; if (pll_ready !== 1'b0) begin errs++; $display("FAIL async_ready got=%b want=0", pll_ready); end
    checks++; if (fail !== 1'b0) begin errs++; $display("FAIL async_fail got=%b want=0", fail); end
    checks++; if (retry_cnt !== 2'd0) begin errs++; $display("FAIL async_retry got=%0d want=0", retry_cnt); end
`ifdef CLKSRC_LOSS_CNT_EN
    checks++; if (loss_cnt !== 8'd0) begin errs++; $display("FAIL async_loss got=%0d want=0", loss_cnt); end
`endif
    model_reset();
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int rem;
    do_reset();
    pll_locked = 1'b0;
    rem = 0;
    repeat (1500) begin
      if (rem == 0) begin
        pll_locked = ~pll_locked;
        rem = int'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 60 : 12));
      end
      rem--;
      soft_rst = ($urandom_range(0, 199) == 0);
      cycle();
      checks++; if (pll_rst !== e_rst()) begin errs++; $display("FAIL rnd_pll_rst cyc=%0d got=%b want=%b", cyc, pll_rst, e_rst()); end
      checks++; if (pll_ready !== e_rdy()) begin errs++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, pll_ready, e_rdy()); end
      checks++; if (fail !== e_fail()) begin errs++; $display("FAIL rnd_fail cyc=%0d got=%b want=%b", cyc, fail, e_fail()); end
      checks++; if (retry_cnt !== 2'(m_retries)) begin errs++; $display("FAIL rnd_retry cyc=%0d got=%0d want=%0d", cyc, retry_cnt, m_retries); end
`ifdef CLKSRC_LOSS_CNT_EN
      checks++; if (loss_cnt !== 8'(m_loss)) begin errs++; $display("FAIL rnd_loss cyc=%0d got=%0d want=%0d", cyc, loss_cnt, m_loss); end
`endif
    end
    soft_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_lock_loss();
    test_timeout_fail();
    test_soft_from_fail();
    test_glitch();
    test_soft_at_timeout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/clksrc_lock_ctrl.md
Name: clksrc_lock_ctrl

Overview:
- Controls the clock-source PLL from the requesting side; runs on the free-running reference clock.
- Drives the PLL reset, synchronizes the PLL's asynchronous `locked`, and qualifies lock as stable before reporting ready.
- On lock failure: times out, re-resets the PLL and retries, up to a limit, then latches a failure.
- Sits between the board reset/refclk and each clksrc PLL instance; `pll_ready` gates downstream reset release.

Parameters:
- RST_CYCLES, 16: refclk cycles `pll_rst` is held high per reset attempt (≥1).
- LOCK_TIMEOUT, 5000: refclk cycles allowed in WAIT_LOCK before a retry (≥2).
- STABLE_CYCLES, 256: consecutive synchronized-locked cycles required before ready (≥1).
- MAX_RETRIES, 3: timeouts tolerated before FAIL (≥1).

Ports:
- refclk  in  1  reference clock, free-running; sole clock.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked; asynchronous to refclk.
- soft_rst  in  1  synchronous single-cycle restart request.
- pll_rst  out  1  PLL reset, active-high.
- pll_ready  out  1  PLL lock qualified stable.
- fail  out  1  sticky retry exhaustion.
- retry_cnt  out  $clog2(MAX_RETRIES+1)  timeouts since last ready or restart.

Behaviour:
- Only legal way to build: one clock and one reset — refclk, with rst_n asynchronous active-low. All flops reset asynchronously on rst_n low.
- Reset values: `pll_rst`=1, `pll_ready`=0, `fail`=0, `retry_cnt`=0, state=RESET_PLL, timer=0.
- `pll_locked` passes through a 2-flop synchronizer → `locked_s`. All decisions use `locked_s` only.
- One shared timer, width $clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1). It clears on every state change.
- All outputs are registered and decoded from next_state, so they change on the same edge as the state.
- RESET_PLL:
  - `pll_rst`=1.
  - After RST_CYCLES cycles in state → WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0.
  - `locked_s`=1 → STABLE.
  - Timer reaches LOCK_TIMEOUT−1 with `locked_s`=0 → `retry_cnt`+1. Then go to FAIL if the new count equals MAX_RETRIES, else RESET_PLL.
- STABLE:
  - `locked_s`=0 → WAIT_LOCK. Timer restarts; `retry_cnt` unchanged.
  - STABLE_CYCLES consecutive cycles with `locked_s`=1 → READY.
- READY:
  - `pll_ready`=1 and `retry_cnt` cleared.
  - `locked_s`=0 → RESET_PLL. `pll_ready` drops and `pll_rst` rises on that same edge.
- FAIL:
  - `pll_rst`=1, `fail`=1.
  - Terminal until `soft_rst` or `rst_n`.
- `soft_rst`=1 in any state:
  - → RESET_PLL next edge, with `retry_cnt`=0, `fail`=0, timer=0.
  - Overrides every other transition in the same cycle.
- `pll_locked` glitches shorter than one refclk may be missed; this is accepted.
- `retry_cnt` never exceeds MAX_RETRIES.

Optional Feature:
- Macro: CLKSRC_LOSS_CNT_EN.
- With it:
  - Extra output `loss_cnt` [7:0], saturating at 255.
  - Increments once per READY→RESET_PLL transition caused by lock loss; never on `soft_rst`.
  - Cleared only by `rst_n`.
- Without it: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package `clksrc_pkg`:
  - enum `clksrc_state_t` {RESET_PLL, WAIT_LOCK, STABLE, READY, FAIL}.
  - Function computing the timer width from the three cycle parameters.
- Sub-module `clksrc_sync2`:
  - 2-flop synchronizer with parameter RST_VAL (default 0), async active-low reset.
  - Reusable by other clksrc consumers.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3):
- Release `rst_n`, raise `pll_locked` 5 cycles after `pll_rst` falls, hold → `pll_rst` high exactly 4 cycles; `pll_ready` rises 10 refclk edges after `pll_locked` rises (2 sync + 8 stable); `retry_cnt`=0.
- `pll_locked` held 0 → three 20-cycle WAIT_LOCK windows, each followed by a 4-cycle `pll_rst` pulse for the first two. After the third timeout: `fail`=1, `pll_rst`=1 permanently, `retry_cnt`=3.
- `pll_locked` high for 5 cycles, low for 3, then high → no `pll_ready` during the glitch; `retry_cnt` unchanged; `pll_ready` rises 10 edges after the final rise.
- In READY, drop `pll_locked` → on the 3rd refclk edge, `pll_ready`=0 and `pll_rst`=1 together; with CLKSRC_LOSS_CNT_EN, `loss_cnt` goes 0→1.
- In FAIL, pulse `soft_rst` → next edge `fail`=0, `retry_cnt`=0, `pll_rst` high 4 cycles, then WAIT_LOCK. `soft_rst` coincident with a timeout → RESET_PLL, `retry_cnt`=0.
- Assert `rst_n` mid-STABLE between clock edges → all outputs take reset values immediately, without waiting for a refclk edge.
